// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: requester and BRAM port bundle for bram_arbiter; lock exists only with BRAM_ARB_LOCK_EN
interface bram_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
`ifdef BRAM_ARB_LOCK_EN
  logic [N_REQ-1:0]    lock;
`endif
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic                bram_en;
  logic [3:0]          bram_wen;
  logic [AW-1:0]       bram_addr;
  logic [DW-1:0]       bram_din;
  logic [DW-1:0]       bram_dout;
  modport slave (
    input  req, we, addr, wdata, bram_dout,
`ifdef BRAM_ARB_LOCK_EN
    input  lock,
`endif
    output gnt, rvalid, rdata, bram_en, bram_wen, bram_addr, bram_din
  );
  modport master (
    output req, we, addr, wdata, bram_dout,
`ifdef BRAM_ARB_LOCK_EN
    output lock,
`endif
    input  gnt, rvalid, rdata, bram_en, bram_wen, bram_addr, bram_din
  );
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter sharing one single-port BRAM; BRAM_ARB_LOCK_EN adds burst lock
module bram_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic           clk,
  input logic           rst,
  bram_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  logic             w_hit;
  logic [PW-1:0]    w_g;
  logic [PW-1:0]    w_next;
  logic [PW:0]      w_idx;
  logic [PW-1:0]    r_rr_ptr;
  logic [N_REQ-1:0] r_rd_pend;
`ifdef BRAM_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           r_state;
  logic [PW-1:0]    r_owner;
  logic             w_lock;
  assign w_lock = bus.lock[w_g];
`endif
  // Winner: first requester at or after rr_ptr (reverse scan so the nearest overwrites); a lock owner overrides
  always_comb begin
    w_hit = 1'b0;
    w_g = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      w_idx = (w_idx >= (PW+1)'(N_REQ)) ? w_idx - (PW+1)'(N_REQ) : w_idx;
      if (bus.req[w_idx[PW-1:0]]) begin
        w_hit = 1'b1;
        w_g = w_idx[PW-1:0];
      end
    end
`ifdef BRAM_ARB_LOCK_EN
    if (r_state == LOCKED) begin
      w_hit = bus.req[r_owner];
      w_g = r_owner;
    end
`endif
    w_hit = w_hit & rst;
  end
  assign w_next = (w_g == PW'(N_REQ - 1)) ? '0 : w_g + 1'b1;
  // Steer the winner onto the BRAM port; everything idles at zero without a grant
  always_comb begin
    bus.gnt = '0;
    bus.bram_en = 1'b0;
    bus.bram_wen = 4'b0000;
    bus.bram_addr = '0;
    bus.bram_din = '0;
    if (w_hit) begin
      bus.gnt[w_g] = 1'b1;
      bus.bram_en = 1'b1;
      bus.bram_wen = {4{bus.we[w_g]}};
      bus.bram_addr = bus.addr[w_g*AW +: AW];
      bus.bram_din = bus.wdata[w_g*DW +: DW];
    end
  end
  assign bus.rvalid = rst ? r_rd_pend : '0;
  assign bus.rdata = bus.bram_dout;
  // Round-robin pointer, in-flight read tag and lock ownership
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr <= '0;
      r_rd_pend <= '0;
`ifdef BRAM_ARB_LOCK_EN
      r_state <= IDLE;
      r_owner <= '0;
`endif
    end else begin
      r_rd_pend <= (w_hit && !bus.we[w_g]) ? N_REQ'(1) << w_g : '0;
`ifdef BRAM_ARB_LOCK_EN
      if (w_hit) begin
        if (r_state == IDLE || !w_lock) r_rr_ptr <= w_next;
        r_state <= w_lock ? LOCKED : IDLE;
        r_owner <= w_g;
      end
`else
      if (w_hit) r_rr_ptr <= w_next;
`endif
    end
  end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed checks of bram_arbiter with a behavioural 1-cycle BRAM
module tb_bram_arbiter;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] mem [0:255];

  bram_arbiter_if #(.N_REQ(3), .AW(32), .DW(32)) bi ();

  bram_arbiter #(.N_REQ(3), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bi.bram_en) begin
      if (bi.bram_wen == 4'hF) mem[bi.bram_addr[9:2]] <= bi.bram_din;
      bi.bram_dout <= mem[bi.bram_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bi.req[i] = r;
    bi.we[i] = w;
    bi.addr[i*32 +: 32] = a;
    bi.wdata[i*32 +: 32] = d;
  endtask

  task automatic idle_all();
    bi.req = '0;
    bi.we = '0;
`ifdef BRAM_ARB_LOCK_EN
    bi.lock = '0;
`endif
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 64'(bi.gnt), 64'h0);
    chk({tag, "_rvalid"}, 64'(bi.rvalid), 64'h0);
    chk({tag, "_en"}, 64'(bi.bram_en), 64'h0);
    chk({tag, "_wen"}, 64'(bi.bram_wen), 64'h0);
    chk({tag, "_addr"}, 64'(bi.bram_addr), 64'h0);
    chk({tag, "_din"}, 64'(bi.bram_din), 64'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[7] = 32'hDEADBEEF;
    rst = 1'b0;
    bi.addr = '0;
    bi.wdata = '0;
    idle_all();
    tick();
    tick();
    // reset holds everything low even with a pending request
    set_req(0, 1'b1, 1'b0, 32'h1C, 32'h0);
    #1;
    chk_quiet("reset");
    tick();
    // single read
    rst = 1'b1;
    #1;
    chk("rd_gnt", 64'(bi.gnt), 64'h1);
    chk("rd_en", 64'(bi.bram_en), 64'h1);
    chk("rd_wen", 64'(bi.bram_wen), 64'h0);
    chk("rd_addr", 64'(bi.bram_addr), 64'h1C);
    tick();
    idle_all();
    #1;
    chk("rd_rvalid", 64'(bi.rvalid), 64'h1);
    chk("rd_rdata", 64'(bi.rdata), 64'hDEADBEEF);
    chk("rd_idle_en", 64'(bi.bram_en), 64'h0);
    chk("rd_idle_addr", 64'(bi.bram_addr), 64'h0);
    // write then read from requester 1
    set_req(1, 1'b1, 1'b1, 32'h40, 32'h12345678);
    #1;
    chk("wr_gnt", 64'(bi.gnt), 64'h2);
    chk("wr_wen", 64'(bi.bram_wen), 64'hF);
    chk("wr_addr", 64'(bi.bram_addr), 64'h40);
    chk("wr_din", 64'(bi.bram_din), 64'h12345678);
    tick();
    set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("wr_no_rvalid", 64'(bi.rvalid), 64'h0);
    chk("wrrd_gnt", 64'(bi.gnt), 64'h2);
    chk("wrrd_wen", 64'(bi.bram_wen), 64'h0);
    tick();
    idle_all();
    #1;
    chk("wrrd_rvalid", 64'(bi.rvalid), 64'h2);
    chk("wrrd_rdata", 64'(bi.rdata), 64'h12345678);
    // three-way contention straight out of reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h1C, 32'h0);
    set_req(1, 1'b1, 1'b1, 32'h40, 32'h0000AAAA);
    set_req(2, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("rr0_gnt", 64'(bi.gnt), 64'h1);
    chk("rr0_rvalid", 64'(bi.rvalid), 64'h0);
    tick();
    chk("rr1_gnt", 64'(bi.gnt), 64'h2);
    chk("rr1_rvalid", 64'(bi.rvalid), 64'h1);
    chk("rr1_rdata", 64'(bi.rdata), 64'hDEADBEEF);
    tick();
    chk("rr2_gnt", 64'(bi.gnt), 64'h4);
    chk("rr2_rvalid", 64'(bi.rvalid), 64'h0);
    tick();
    chk("rr3_gnt", 64'(bi.gnt), 64'h1);
    chk("rr3_rvalid", 64'(bi.rvalid), 64'h4);
    chk("rr3_rdata", 64'(bi.rdata), 64'h0000AAAA);
    tick();
    chk("rr4_gnt", 64'(bi.gnt), 64'h2);
    chk("rr4_rvalid", 64'(bi.rvalid), 64'h1);
    tick();
    chk("rr5_gnt", 64'(bi.gnt), 64'h4);
    chk("rr5_rvalid", 64'(bi.rvalid), 64'h0);
    tick();
    idle_all();
    #1;
    chk("rr6_rvalid", 64'(bi.rvalid), 64'h4);
    chk("rr6_gnt", 64'(bi.gnt), 64'h0);
    // simultaneous 0 and 2 after a grant to 0
    set_req(0, 1'b1, 1'b0, 32'h1C, 32'h0);
    #1;
    chk("sim_first_gnt", 64'(bi.gnt), 64'h1);
    tick();
    set_req(2, 1'b1, 1'b1, 32'h80, 32'h55);
    #1;
    chk("sim_gnt2", 64'(bi.gnt), 64'h4);
    chk("sim_din2", 64'(bi.bram_din), 64'h55);
    chk("sim_addr2", 64'(bi.bram_addr), 64'h80);
    tick();
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("sim_gnt0", 64'(bi.gnt), 64'h1);
    tick();
    idle_all();
    // reset in the cycle after a granted read
    set_req(0, 1'b1, 1'b0, 32'h1C, 32'h0);
    #1;
    chk("mid_gnt", 64'(bi.gnt), 64'h1);
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b1, 32'h44, 32'h99);
    #1;
    chk_quiet("midrst");
    tick();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h1C, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h80, 32'h0);
    #1;
    chk("post_rst_gnt", 64'(bi.gnt), 64'h1);
    chk("post_rst_addr", 64'(bi.bram_addr), 64'h1C);
    chk("post_rst_rvalid", 64'(bi.rvalid), 64'h0);
    tick();
    idle_all();
`ifdef BRAM_ARB_LOCK_EN
    // requester 1 locks for four writes while 0 and 2 wait
    set_req(0, 1'b1, 1'b0, 32'h1C, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h80, 32'h0);
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1'b1, 1'b1, 32'h100 + 32'(b*4), 32'(b));
      bi.lock[1] = (b < 3);
      #1;
      chk("lock_gnt1", 64'(bi.gnt), 64'h2);
      chk("lock_addr", 64'(bi.bram_addr), 64'(32'h100 + 32'(b*4)));
      tick();
    end
    bi.lock = '0;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("unlock_gnt2", 64'(bi.gnt), 64'h4);
    tick();
    chk("unlock_gnt0", 64'(bi.gnt), 64'h1);
    tick();
    idle_all();
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Round-robin access arbiter that shares one single-port feature/weight BRAM between up to N requesters (weight loader, convolution engine, result writer) in the LeNet-5 accelerator. Each cycle it grants at most one pending request, drives the BRAM's byte-addressed port, and steers the 1-cycle-latency read data back to the requester that issued the read. With the lock feature compiled in, a requester can hold the BRAM across a burst.

## Interface
- N_REQ, 3, number of requesters (2..8)
- AW, 32, byte-address width, matching the BRAM port
- DW, 32, data width
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset; synchronous, active-low
- req  in  N_REQ  per-requester access request; held until granted
- we  in  N_REQ  1 = write, 0 = read; valid while req is high
- addr  in  N_REQ*AW  byte address, slice i = requester i; must be word-aligned
- wdata  in  N_REQ*DW  write data, slice i = requester i
- lock  in  N_REQ  keep ownership after the grant; present only with BRAM_ARB_LOCK_EN
- gnt  out  N_REQ  one-hot; access is issued to the BRAM this cycle
- rvalid  out  N_REQ  one-hot; rdata is valid for this requester this cycle
- rdata  out  DW  shared read data, equal to bram_dout
- bram_en  out  1  BRAM enable
- bram_wen  out  4  4'b1111 on a granted write, else 4'b0000
- bram_addr  out  AW  byte address of the granted requester, passed unchanged
- bram_din  out  DW  write data of the granted requester
- bram_dout  in  DW  BRAM read data; valid 1 cycle after an enabled read

## Operation
- State:
  - rr_ptr: index of the highest-priority requester.
  - owner / state: IDLE or LOCKED.
  - rd_pend: one-hot register of the requester whose read is in flight.
- Grant, combinational from req, rr_ptr and state:
  - IDLE: the first requester with req high, scanning from rr_ptr upward with wrap-around, is granted.
  - No req high: gnt=0, bram_en=0, bram_wen=0, and bram_addr/bram_din hold 0.
- Mux on a grant to requester g:
  - bram_en=1, bram_addr=addr[g], bram_din=wdata[g].
  - bram_wen=4'b1111 if we[g], else 0.
- Pointer update on a grant to g: rr_ptr <= (g+1) mod N_REQ.
- Read return:
  - A granted read loads rd_pend <= onehot(g); otherwise rd_pend <= 0.
  - rvalid = rd_pend, and rdata = bram_dout.
- Requester rules:
  - Drop req, or present the next access, in the cycle after gnt.
  - Keeping req high issues a new access each cycle the requester wins.
- Misaligned addr is not checked; the BRAM drops addr[1:0].

## Timing
- Grant is combinational: 0 cycles from req to gnt/bram_en. Each grant is a full-word BRAM access.
- Read latency: data appears 1 cycle after gnt, on rvalid/rdata.
- Throughput: 1 access per cycle, back-to-back reads/writes from any mix of requesters.
- Fairness: with all requesters asserting continuously, each is granted exactly once every N_REQ cycles.
- Same-address access:
  - Write in cycle t, read of the same address in cycle t+1: returns the new data at t+2.
  - Read and write to the same address in the same cycle is impossible, since there is one grant per cycle.
- Reset (rst=0 at a clock edge): rr_ptr=0, state=IDLE, rd_pend=0.
  - While rst=0: gnt=0, rvalid=0, bram_en=0, bram_wen=0, bram_addr=0, bram_din=0.
  - A read granted in the cycle before reset returns no rvalid; its data is discarded.

## Configuration
- BRAM_ARB_LOCK_EN defined: the lock input exists.
  - Grant to g with lock[g]=1: state <= LOCKED, owner <= g.
  - In LOCKED only owner can be granted; other requests wait.
  - If owner has req low, no grant is issued.
  - Leaves LOCKED on the first grant to owner with lock[owner]=0: rr_ptr <= owner+1, state <= IDLE.
  - rr_ptr does not advance while LOCKED.
  - Reset clears LOCKED.
- BRAM_ARB_LOCK_EN undefined: no lock port, state is always IDLE, and there is pure round-robin.

## Test plan
- Single read: BRAM preloaded word 7 = 0xDEADBEEF; req0 read addr 0x1C → gnt0 at t, bram_en=1, bram_wen=0, and rvalid0=1 with rdata=0xDEADBEEF at t+1.
- Write then read: req1 write 0x12345678 to 0x40, then read 0x40 the next cycle → rvalid1 with 0x12345678.
- Contention, N_REQ=3: all req high for 6 cycles from reset → grant order 0,1,2,0,1,2; rvalid follows only for the read grants.
- Simultaneous two-way: after a grant to 0, req0 and req2 rise together → req2 is granted before req0.
- Reset mid-read: rst=0 in the cycle after a granted read → rvalid=0 and all outputs 0; after release req0 is granted first.
- Lock (BRAM_ARB_LOCK_EN): req1 holds lock for 4 writes while req0 and req2 are pending → 4 consecutive gnt1, then gnt2, then gnt0.
